// File: rtl/fifo_seq_pkg.sv
// Shared types and timing constants for the frame FIFO sequencer.
package fifo_seq_pkg;

    // Cycles fifo_wr_en / fifo_rd_en are held before the first strobe edge.
    localparam int unsigned ARM_CYCLES   = 2;
    // Cycles allowed for fifo_full to assert after the last write.
    localparam int unsigned FULL_TIMEOUT = 4;
    // Width of the shared arm/timeout timer.
    localparam int unsigned TMR_W        = 3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ARM,
        S_WR_TAKE,
        S_WR_HI,
        S_WR_LO,
        S_WAIT_FULL,
        S_RD_ARM,
        S_RD_HI,
        S_RD_LO,
        S_RD_OUT,
        S_DONE
    } state_t;

endpackage

// File: rtl/fifo_seq_ctrl.sv
// Frame FIFO sequencer: captures DEPTH samples from a valid/ready source into
// the block-mode FIFO, then drains them to a valid/ready sink.
// Optional feature macro FIFO_SEQ_DECIM_EN adds the decim input (keep 1 of
// every decim accepted samples).
module fifo_seq_ctrl
    import fifo_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DEPTH  = 1000,
    parameter int unsigned CNT_W  = 10
) (
    input  logic              clk_100M,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
`ifdef FIFO_SEQ_DECIM_EN
    input  logic [7:0]        decim,
`endif
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              fifo_rst_n,
    output logic              fifo_wr_en,
    output logic              fifo_wr_clk,
    output logic              fifo_rd_en,
    output logic              fifo_rd_clk,
    output logic [DATA_W-1:0] fifo_din,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] ARM_LAST = TMR_W'(ARM_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(FULL_TIMEOUT - 1);

    state_t             state, state_d;
    logic [CNT_W-1:0]   wcnt, wcnt_d;
    logic [CNT_W-1:0]   rcnt, rcnt_d;
    logic [TMR_W-1:0]   tmr, tmr_d;
    logic [DATA_W-1:0]  din_d, mdata_d;
    logic               err_d;
    logic               s_ready_d, m_valid_d;
    logic               wr_en_d, wr_clk_d, rd_en_d, rd_clk_d;
    logic               busy_d, frame_done_d;
    logic               hs_in;
`ifdef FIFO_SEQ_DECIM_EN
    logic [7:0]         phase, phase_d;
`endif

    assign hs_in = s_valid && s_ready;

    // Next-state, counter, data-capture and registered-output decode.
    always_comb begin
        state_d = state;
        wcnt_d  = wcnt;
        rcnt_d  = rcnt;
        din_d   = fifo_din;
        mdata_d = m_data;
        err_d   = err;
`ifdef FIFO_SEQ_DECIM_EN
        phase_d = phase;
`endif

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (fifo_empty) begin
                        state_d = S_WR_ARM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WR_ARM: begin
`ifdef FIFO_SEQ_DECIM_EN
                phase_d = '0;
`endif
                if (tmr == ARM_LAST) begin
                    state_d = S_WR_TAKE;
                end
            end
            S_WR_TAKE: begin
                if (hs_in) begin
`ifdef FIFO_SEQ_DECIM_EN
                    // Phase 0 is the kept sample; others are acked and dropped.
                    if (phase == 8'd0) begin
                        din_d   = s_data;
                        state_d = S_WR_HI;
                    end
                    if ((decim <= 8'd1) || (phase >= 8'(decim - 8'd1))) begin
                        phase_d = '0;
                    end else begin
                        phase_d = 8'(phase + 8'd1);
                    end
`else
                    din_d   = s_data;
                    state_d = S_WR_HI;
`endif
                end
            end
            S_WR_HI: begin
                if (wcnt < CNT_FULL) begin
                    wcnt_d = wcnt + CNT_W'(1);
                end
                state_d = S_WR_LO;
            end
            S_WR_LO: begin
                state_d = (wcnt == CNT_FULL) ? S_WAIT_FULL : S_WR_TAKE;
            end
            S_WAIT_FULL: begin
                if (fifo_full) begin
                    state_d = S_RD_ARM;
                end else if (tmr == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RD_ARM;
                end
            end
            S_RD_ARM: begin
                if (tmr == ARM_LAST) begin
                    state_d = S_RD_HI;
                end
            end
            S_RD_HI: begin
                state_d = S_RD_LO;
            end
            S_RD_LO: begin
                mdata_d = fifo_dout;
                if (rcnt < CNT_FULL) begin
                    rcnt_d = rcnt + CNT_W'(1);
                end
                state_d = S_RD_OUT;
            end
            S_RD_OUT: begin
                if (m_ready) begin
                    // FIFO must report empty exactly after the last word.
                    if (fifo_empty != (rcnt == CNT_FULL)) begin
                        err_d = 1'b1;
                    end
                    state_d = (rcnt == CNT_FULL) ? S_DONE : S_RD_HI;
                end
            end
            S_DONE: begin
                wcnt_d  = '0;
                rcnt_d  = '0;
                state_d = continuous ? S_WR_ARM : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // FIFO claiming full before the whole frame is written is a fault.
        if (((state == S_WR_TAKE) || (state == S_WR_HI) || (state == S_WR_LO))
            && fifo_full && (wcnt != CNT_FULL)) begin
            err_d = 1'b1;
        end

        // Timer restarts on every state change and saturates otherwise.
        if (state_d != state) begin
            tmr_d = '0;
        end else if (tmr != '1) begin
            tmr_d = tmr + TMR_W'(1);
        end else begin
            tmr_d = tmr;
        end

        s_ready_d    = (state_d == S_WR_TAKE);
        wr_en_d      = (state_d == S_WR_ARM) || (state_d == S_WR_TAKE) ||
                       (state_d == S_WR_HI)  || (state_d == S_WR_LO);
        wr_clk_d     = (state_d == S_WR_HI);
        rd_en_d      = (state_d == S_RD_ARM) || (state_d == S_RD_HI) ||
                       (state_d == S_RD_LO)  || (state_d == S_RD_OUT);
        rd_clk_d     = (state_d == S_RD_HI);
        m_valid_d    = (state_d == S_RD_OUT);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_DONE) && (state != S_DONE);
    end

    // State, counters and all registered outputs; synchronous reset.
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state       <= S_IDLE;
            wcnt        <= '0;
            rcnt        <= '0;
            tmr         <= '0;
            fifo_din    <= '0;
            m_data      <= '0;
            err         <= 1'b0;
            s_ready     <= 1'b0;
            m_valid     <= 1'b0;
            fifo_wr_en  <= 1'b0;
            fifo_wr_clk <= 1'b0;
            fifo_rd_en  <= 1'b0;
            fifo_rd_clk <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            fifo_rst_n  <= 1'b0;
`ifdef FIFO_SEQ_DECIM_EN
            phase       <= '0;
`endif
        end else begin
            state       <= state_d;
            wcnt        <= wcnt_d;
            rcnt        <= rcnt_d;
            tmr         <= tmr_d;
            fifo_din    <= din_d;
            m_data      <= mdata_d;
            err         <= err_d;
            s_ready     <= s_ready_d;
            m_valid     <= m_valid_d;
            fifo_wr_en  <= wr_en_d;
            fifo_wr_clk <= wr_clk_d;
            fifo_rd_en  <= rd_en_d;
            fifo_rd_clk <= rd_clk_d;
            busy        <= busy_d;
            frame_done  <= frame_done_d;
            fifo_rst_n  <= 1'b1;
`ifdef FIFO_SEQ_DECIM_EN
            phase       <= phase_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_seq_ctrl.sv
// Bench for fifo_seq_ctrl with DEPTH=4 and a behavioural block-mode FIFO.
module tb_fifo_seq_ctrl;

    localparam int unsigned DW    = 12;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    // Flag vector order: busy s_ready wr_en wr_clk rd_en rd_clk m_valid frame_done err
    localparam logic [8:0] F_IDLE = 9'b000000000;
    localparam logic [8:0] F_ARM  = 9'b101000000;
    localparam logic [8:0] F_TAKE = 9'b111000000;
    localparam logic [8:0] F_WHI  = 9'b101100000;
    localparam logic [8:0] F_WLO  = 9'b101000000;
    localparam logic [8:0] F_WAIT = 9'b100000000;
    localparam logic [8:0] F_RARM = 9'b100010000;
    localparam logic [8:0] F_RHI  = 9'b100011000;
    localparam logic [8:0] F_RLO  = 9'b100010000;
    localparam logic [8:0] F_ROUT = 9'b100010100;
    localparam logic [8:0] F_DONE = 9'b100000010;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;
    logic          fifo_rst_n;
    logic          fifo_wr_en, fifo_wr_clk, fifo_rd_en, fifo_rd_clk;
    logic [DW-1:0] fifo_din;
    logic          fifo_full, fifo_empty;
    logic [DW-1:0] fifo_dout = '0;
    logic          busy, frame_done, err;
`ifdef FIFO_SEQ_DECIM_EN
    logic [7:0]    decim = 8'd1;
`endif

    always #5 clk = ~clk;

    fifo_seq_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk_100M    (clk),
        .rst         (rst),
        .start       (start),
        .continuous  (continuous),
`ifdef FIFO_SEQ_DECIM_EN
        .decim       (decim),
`endif
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .fifo_rst_n  (fifo_rst_n),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_clk (fifo_wr_clk),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_clk (fifo_rd_clk),
        .fifo_din    (fifo_din),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .fifo_dout   (fifo_dout),
        .busy        (busy),
        .frame_done  (frame_done),
        .err         (err)
    );

    // Behavioural FIFO: pushes/pops on strobe rising edges seen against a delayed copy.
    logic [DW-1:0] fmem[$];
    int            fcnt = 0;
    logic          wr_clk_q = 1'b0, rd_clk_q = 1'b0;
    logic          force_full = 1'b0, force_notempty = 1'b0;

    assign fifo_full  = (fcnt == int'(DEPTH)) || force_full;
    assign fifo_empty = (fcnt == 0) && !force_notempty;

    always @(posedge clk) begin
        wr_clk_q <= fifo_wr_clk;
        rd_clk_q <= fifo_rd_clk;
        if (!fifo_rst_n) begin
            fmem.delete();
            fcnt      <= 0;
            fifo_dout <= '0;
        end else begin
            if (fifo_wr_en && fifo_wr_clk && !wr_clk_q && fmem.size() < int'(DEPTH))
                fmem.push_back(fifo_din);
            if (fifo_rd_en && fifo_rd_clk && !rd_clk_q && fmem.size() > 0)
                fifo_dout <= fmem.pop_front();
            fcnt <= fmem.size();
        end
    end

    wire [8:0] flags_now = {busy, s_ready, fifo_wr_en, fifo_wr_clk, fifo_rd_en,
                            fifo_rd_clk, m_valid, frame_done, err};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic          start;
        logic [DW-1:0] sdata;
        logic          m_ready;
        logic [8:0]    flags;
        logic [DW-1:0] mdata;
    } vec_t;

    vec_t tbl [0:39];
    int   ntbl = 0;

    task automatic add_row(input logic st, input int sd, input logic [8:0] fl, input int md);
        tbl[ntbl] = '{start: st, sdata: DW'(sd), m_ready: 1'b1, flags: fl, mdata: DW'(md)};
        ntbl++;
    endtask

    // Cycle-by-cycle expectation of one stall-free frame of words 1..DEPTH.
    task automatic build_table();
        ntbl = 0;
        add_row(1'b1, 1, F_ARM, 0);
        add_row(1'b0, 1, F_ARM, 0);
        add_row(1'b0, 1, F_TAKE, 0);
        for (int w = 1; w <= int'(DEPTH); w++) begin
            add_row(1'b0, w, F_WHI, 0);
            add_row(1'b0, w + 1, F_WLO, 0);
            add_row(1'b0, w + 1, (w < int'(DEPTH)) ? F_TAKE : F_WAIT, 0);
        end
        add_row(1'b0, 0, F_RARM, 0);
        add_row(1'b0, 0, F_RARM, 0);
        for (int k = 1; k <= int'(DEPTH); k++) begin
            add_row(1'b0, 0, F_RHI, k - 1);
            add_row(1'b0, 0, F_RLO, k - 1);
            add_row(1'b0, 0, F_ROUT, k);
        end
        add_row(1'b0, 0, F_DONE, DEPTH);
        add_row(1'b0, 0, F_IDLE, DEPTH);
    endtask

    task automatic run_table(input string tag);
        s_valid    = 1'b1;
        continuous = 1'b0;
        for (int i = 0; i < ntbl; i++) begin
            start   = tbl[i].start;
            s_data  = tbl[i].sdata;
            m_ready = tbl[i].m_ready;
            @(negedge clk);
            chk($sformatf("%s_row%0d", tag, i), 32'({flags_now, m_data}),
                32'({tbl[i].flags, tbl[i].mdata}));
        end
        start   = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; m_ready = 1'b0; continuous = 1'b0;
        force_full = 1'b0; force_notempty = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_flags", 32'({fifo_rst_n, flags_now}), 32'd0);
        chk("reset_data", 32'({m_data, fifo_din}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_release_fifo_rst_n", 32'(fifo_rst_n), 32'd1);
    endtask

    // Scoreboarded stream: expected output order is the kept accepted samples.
    task automatic run_stream(input string tag, input int nf, input bit rnd,
                              input int d, input int stall_word);
        logic [DW-1:0] q_exp[$];
        logic [DW-1:0] seq = DW'(1);
        logic [DW-1:0] prev_data = '0;
        logic [DW-1:0] exp_w;
        int  frames = 0, words = 0, acc = 0, kept = 0, stall_left = 0, busy_low = 0;
        bit  prev_stall = 1'b0, stall_done = 1'b0, finished = 1'b0;
`ifdef FIFO_SEQ_DECIM_EN
        decim = 8'(d);
`endif
        continuous = (nf > 1);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (prev_stall) begin
                chk({tag, "_hold_valid"}, 32'(m_valid), 32'd1);
                chk({tag, "_hold_data"}, 32'(m_data), 32'(prev_data));
            end
            if (frame_done) begin
                frames++;
                continuous = (frames < nf);
            end
            if (cyc > 0 && frames < nf && !busy) busy_low++;
            if (cyc > 0 && frames >= nf && !busy) begin
                finished = 1'b1;
                break;
            end
            start   = (cyc == 0);
            s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data  = rnd ? DW'($urandom) : seq;
            if (stall_word != 0 && !stall_done && m_valid && m_data == DW'(stall_word)) begin
                stall_left = 5;
                stall_done = 1'b1;
            end
            if (stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
                chk({tag, "_no_rdclk_in_stall"}, 32'(fifo_rd_clk), 32'd0);
            end else begin
                m_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            if (s_valid && s_ready) begin
                if (d <= 1 || (acc % d) == 0) begin
                    q_exp.push_back(s_data);
                    kept++;
                end
                acc++;
                if (!rnd) seq = seq + DW'(1);
                if (kept == int'(DEPTH)) begin
                    acc  = 0;
                    kept = 0;
                end
            end
            if (m_valid && m_ready) begin
                chk({tag, "_word_expected"}, 32'(q_exp.size() > 0), 32'd1);
                if (q_exp.size() > 0) begin
                    exp_w = q_exp.pop_front();
                    chk($sformatf("%s_word%0d", tag, words), 32'(m_data), 32'(exp_w));
                end
                words++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            @(negedge clk);
        end
        chk({tag, "_finished"}, 32'(finished), 32'd1);
        chk({tag, "_frames"}, 32'(frames), 32'(nf));
        chk({tag, "_words"}, 32'(words), 32'(nf * int'(DEPTH)));
        chk({tag, "_leftover"}, 32'(q_exp.size()), 32'd0);
        chk({tag, "_busy_gap"}, 32'(busy_low), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        start = 1'b0; s_valid = 1'b0; m_ready = 1'b0; continuous = 1'b0;
    endtask

    // Assert rst while word 3 is in its wr_clk-high cycle.
    task automatic mid_reset();
        int pulses = 0;
        bit hit = 1'b0;
        s_valid = 1'b1; m_ready = 1'b1; s_data = DW'(1); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (fifo_wr_clk) begin
                pulses++;
                if (pulses == 3) begin
                    hit = 1'b1;
                    break;
                end
            end
            s_data = DW'(pulses + 1);
            @(negedge clk);
        end
        chk("midrst_reached_word3", 32'(hit), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_flags", 32'({fifo_rst_n, flags_now}), 32'd0);
        chk("midrst_data", 32'({m_data, fifo_din}), 32'd0);
        rst = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        chk("midrst_fifo_rst_n_high", 32'(fifo_rst_n), 32'd1);
        chk("midrst_fifo_emptied", 32'(fifo_empty), 32'd1);
    endtask

    task automatic early_full();
        bit seen = 1'b0;
        s_valid = 1'b1; m_ready = 1'b1; s_data = DW'(1); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (fcnt >= 2) force_full = 1'b1;
            if (err) seen = 1'b1;
            @(negedge clk);
        end
        chk("early_full_err_seen", 32'(seen), 32'd1);
        chk("early_full_err_sticky", 32'(err), 32'd1);
        chk("early_full_idle", 32'(busy), 32'd0);
        do_reset();
        chk("early_full_err_cleared", 32'(err), 32'd0);
    endtask

    initial begin
        build_table();
        do_reset();
        run_table("frame");
        run_stream("stall", 1, 1'b0, 1, 2);
        run_stream("cont", 2, 1'b0, 1, 0);
        mid_reset();
        run_table("after_rst");
        early_full();

        // start with a non-empty FIFO is refused and flagged
        force_notempty = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_notempty_err", 32'(err), 32'd1);
        chk("start_notempty_idle", 32'(busy), 32'd0);
        do_reset();

`ifdef FIFO_SEQ_DECIM_EN
        run_stream("decim2", 1, 1'b0, 2, 0);
        run_stream("decim3_rnd", 3, 1'b1, 3, 0);
        run_stream("decim0", 1, 1'b0, 0, 0);
`endif
        for (int r = 0; r < 5; r++) begin
            run_stream($sformatf("rand%0d", r), int'($urandom_range(1, 3)), 1'b1, 1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_seq_ctrl.md
# fifo_seq_ctrl

Sequencer for the block-mode frame FIFO: it produces the FIFO's level-sensitive `wr_en`/`rd_en` and edge-sampled `wr_clk`/`rd_clk` strobes so that one full frame of `DEPTH` samples is captured from an upstream valid/ready source and then drained to a downstream valid/ready sink. It sits between the ADC sample path and the readout path (UART/processing), in the same `clk_100M` domain as the FIFO. The FIFO's `wr_full`/`rd_empty` flags are authoritative; an internal word counter cross-checks them.

## Interface
- `DATA_W`, 12: sample width; equals the FIFO data width.
- `DEPTH`, 1000: words per frame; equals the FIFO data depth.
- `CNT_W`, 10: counter width; `2**CNT_W >= DEPTH`.
- `clk_100M` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a frame when the block is idle.
- `continuous` in 1: sampled in DONE; when 1, the block starts the next frame automatically.
- `s_valid` in 1: source sample valid.
- `s_data` in DATA_W: source sample.
- `s_ready` out 1: source handshake.
- `m_valid` out 1: sink word valid.
- `m_data` out DATA_W: sink word.
- `m_ready` in 1: sink handshake.
- `fifo_rst_n` out 1: FIFO reset; registered `~rst`.
- `fifo_wr_en`, `fifo_wr_clk`, `fifo_rd_en`, `fifo_rd_clk` out 1: FIFO control strobes.
- `fifo_din` out DATA_W: FIFO write data.
- `fifo_full`, `fifo_empty` in 1: FIFO `wr_full`/`rd_empty`.
- `fifo_dout` in DATA_W: FIFO read data.
- `busy` out 1: high whenever the state is not IDLE.
- `frame_done` out 1: one-cycle pulse on entry to DONE.
- `err` out 1: sticky flag; cleared only by `rst`.
- `decim` in 8: decimation ratio; exists only with `FIFO_SEQ_DECIM_EN`.

## Operation
- Reset values: all strobes 0, `fifo_din`=0, `m_data`=0, `m_valid`=0, `s_ready`=0, `busy`=0, `frame_done`=0, `err`=0, `fifo_rst_n`=0, state=IDLE, counters=0.
- IDLE, on `start` → WR_ARM if `fifo_empty`=1; otherwise `err`←1 and the block stays in IDLE.
- WR_ARM:
  - Raise `fifo_wr_en`, hold it for 2 cycles so the FIFO's write mode latches, then go to WR_TAKE.
  - `fifo_rd_en`=0 throughout the write phase.
- WR_TAKE: `s_ready`=1. On `s_valid&&s_ready`: `fifo_din`←`s_data`, then WR_HI.
- WR_HI: `fifo_wr_clk`=1 for 1 cycle; `wcnt`++; then WR_LO.
- WR_LO:
  - `fifo_wr_clk`=0 for 1 cycle.
  - If `wcnt`==DEPTH: go to WAIT_FULL. Otherwise return to WR_TAKE.
- WAIT_FULL:
  - Drop `fifo_wr_en`.
  - When `fifo_full`=1 → RD_ARM.
  - If `fifo_full` is still 0 after 4 cycles, `err`←1 and the block proceeds to RD_ARM anyway.
  - `fifo_full` rising before `wcnt`==DEPTH also sets `err`.
- RD_ARM: raise `fifo_rd_en` and hold it 2 cycles → RD_HI.
- RD_HI: `fifo_rd_clk`=1 for 1 cycle → RD_LO.
- RD_LO: `fifo_rd_clk`=0 for 1 cycle. `fifo_dout` is valid now. Capture `m_data`←`fifo_dout`, `m_valid`←1, `rcnt`++ → RD_OUT.
- RD_OUT: hold `m_valid`/`m_data` until `m_ready`.
  - Then, if `rcnt`==DEPTH → DONE; otherwise → RD_HI.
  - `fifo_empty` must be 1 exactly when `rcnt`==DEPTH; any mismatch sets `err`.
- DONE:
  - Drop `fifo_rd_en`; pulse `frame_done`; clear counters.
  - Next state is WR_ARM if `continuous`, else IDLE.
- `start` outside IDLE is ignored.
- `s_ready` is 0 in every state except WR_TAKE.
- `m_valid` is 1 only in RD_OUT.
- `rst` mid-frame:
  - All outputs return to their reset values on the next edge.
  - `fifo_rst_n` is low during that cycle and goes high 1 cycle after `rst` falls, so the FIFO is re-emptied.
- Counters saturate at DEPTH; they never wrap.

## Timing
- Strobes are registered outputs. Minimum strobe high and low time is 1 cycle each, because the FIFO detects edges against a 1-cycle delayed copy.
- Write throughput: at most 1 word per 3 cycles (TAKE/HI/LO) with `s_valid` held high.
- Latency from `start` to first `s_ready`: 3 cycles.
- Read throughput: at most 1 word per 3 cycles with `m_ready` held high.
- `fifo_rd_clk` rise to `m_valid`: 2 cycles.
- Frame time with no stalls: 2+3·DEPTH+1 (write) + 2+3·DEPTH (read) + 1 cycles. For DEPTH=4 that is 30 cycles.

## Configuration
- `FIFO_SEQ_DECIM_EN` defined:
  - WR_TAKE keeps 1 of every `decim` accepted samples. Skipped samples are acknowledged (`s_ready`=1) but not written.
  - `decim`=0 or 1 means no decimation.
  - The decimation phase counter resets at WR_ARM.
- Not defined: the `decim` port is absent and every accepted sample is written.

## Structure
- Package `fifo_seq_pkg`: state enumeration, `ARM_CYCLES`=2, `FULL_TIMEOUT`=4.
- No sub-module is natural; this is a single FSM with two counters. The FIFO is instantiated alongside the block by the parent, not inside it.

## Test plan
Benches use DEPTH=4 and a behavioural FIFO model.
- Reset, then `start` with `s_data`=1,2,3,4 and `m_ready`=1 → `m_data` sequence 1,2,3,4; `frame_done` is a single pulse; `err`=0.
- Sink stalls (`m_ready` low for 5 cycles on word 2) → `m_valid`/`m_data`=2 held stable; no extra `fifo_rd_clk` edge during the stall.
- `continuous`=1 over two frames (1..4, then 5..8) → 8 words output in order; `busy` never drops between the frames.
- `rst` asserted in WR_HI of word 3 → all outputs at reset values next cycle; `fifo_rst_n` low; a new `start` afterwards yields a clean frame.
- FIFO model forces `fifo_full` early (after word 2) → `err`=1 and stays 1 until `rst`.
- With `FIFO_SEQ_DECIM_EN`, `decim`=2, source 1..8 → written and output words are 1,3,5,7.
